// File: rtl/key_event_scheduler.sv
// key_event_scheduler: multi-channel key press detector with per-channel lockout,
// single-bit pending queue per request slot and a round-robin valid/ready event port.
// Optional release events are enabled by defining KEY_EVENT_RELEASE_EN; the default
// build reports presses only and ties oEvent_release to 0.
module key_event_scheduler #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned ID_W       = 2,
   parameter logic [15:0] LOCKOUT    = 16'd50000,
   parameter logic [7:0]  GAP_CYCLES = 8'd4
) (
   input  logic            iCLK,
   input  logic            iRST_n,
   input  logic [N_CH-1:0] iTrigger_in,
   input  logic            iEvent_ready,
   output logic            oEvent_valid,
   output logic [ID_W-1:0] oEvent_id,
   output logic            oEvent_release,
   output logic [N_CH-1:0] oPending,
   output logic            oBusy,
   output logic            oDrop_pulse
);

`ifdef KEY_EVENT_RELEASE_EN
   // Two request slots per channel: even slot = press, odd slot = release.
   localparam int unsigned SPC = 2;
`else
   localparam int unsigned SPC = 1;
`endif
   localparam int unsigned NS = N_CH * SPC;
   localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

   logic [N_CH-1:0] r_older;
   logic [N_CH-1:0] r_newer;
   logic [15:0]     r_lock [NS];
   logic [NS-1:0]   r_pend;
   logic [SW-1:0]   r_ptr;
   logic [SW-1:0]   r_slot;
   logic [7:0]      r_gap;
   state_e          r_state;
   logic            r_valid;
   logic [ID_W-1:0] r_id;
`ifdef KEY_EVENT_RELEASE_EN
   logic            r_rel;
`endif

   logic [NS-1:0]   w_edge;
   logic [NS-1:0]   w_acc;
   logic [NS-1:0]   w_clr;
   logic            w_hs;
   logic            w_found;
   logic [SW-1:0]   w_sel;
   logic [ID_W-1:0] w_sel_id;
   logic            w_sel_rel;
   logic [SW-1:0]   w_ptr_next;

   // Two-stage delay line per channel; reset to idle-high so no edge appears after reset.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_older <= '1;
         r_newer <= '1;
      end else begin
         r_newer <= iTrigger_in;
         r_older <= r_newer;
      end
   end

   // Edge flags mapped onto request slots.
   always_comb begin
      w_edge = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
`ifdef KEY_EVENT_RELEASE_EN
         w_edge[2*c]   = r_older[c] & ~r_newer[c];
         w_edge[2*c+1] = ~r_older[c] & r_newer[c];
`else
         w_edge[c]     = r_older[c] & ~r_newer[c];
`endif
      end
   end

   assign w_hs = (r_state == StOffer) && iEvent_ready;

   // Handshake clears exactly the slot being offered.
   always_comb begin
      w_clr = '0;
      if (w_hs) w_clr[r_slot] = 1'b1;
   end

   // Accept when lockout expired and the slot is free (or being freed this cycle).
   always_comb begin
      w_acc = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         w_acc[s] = w_edge[s] && (r_lock[s] == 16'd0) && (!r_pend[s] || w_clr[s]);
      end
   end

   assign oDrop_pulse = |(w_edge & ~w_acc);

   // Lockout counters: load on accept, otherwise count down to zero.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int unsigned s = 0; s < NS; s++) r_lock[s] <= 16'd0;
      end else begin
         for (int unsigned s = 0; s < NS; s++) begin
            if (w_acc[s]) begin
               r_lock[s] <= LOCKOUT;
            end else if (r_lock[s] != 16'd0) begin
               r_lock[s] <= r_lock[s] - 16'd1;
            end
         end
      end
   end

   // Pending bits; a set in the same cycle as a clear wins.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_acc;
      end
   end

   // Round-robin pick: first pending slot at or above the pointer, wrapping.
   always_comb begin
      int unsigned idx;
      w_found = 1'b0;
      w_sel   = '0;
      idx     = 0;
      for (int unsigned i = 0; i < NS; i++) begin
         idx = 32'(r_ptr) + i;
         if (idx >= NS) idx = idx - NS;
         if (!w_found && r_pend[idx]) begin
            w_found = 1'b1;
            w_sel   = SW'(idx);
         end
      end
   end

`ifdef KEY_EVENT_RELEASE_EN
   assign w_sel_id  = ID_W'(w_sel >> 1);
   assign w_sel_rel = w_sel[0];
`else
   assign w_sel_id  = ID_W'(w_sel);
   assign w_sel_rel = 1'b0;
`endif

   assign w_ptr_next = (r_slot == SW'(NS - 1)) ? '0 : r_slot + 1'b1;

   // Handoff FSM with registered valid/id outputs.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state <= StIdle;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_slot  <= '0;
         r_ptr   <= '0;
         r_gap   <= 8'd0;
`ifdef KEY_EVENT_RELEASE_EN
         r_rel   <= 1'b0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_slot  <= w_sel;
                  r_id    <= w_sel_id;
                  r_valid <= 1'b1;
`ifdef KEY_EVENT_RELEASE_EN
                  r_rel   <= w_sel_rel;
`endif
                  r_state <= StOffer;
               end
            end
            StOffer: begin
               if (iEvent_ready) begin
                  r_valid <= 1'b0;
                  r_ptr   <= w_ptr_next;
                  r_gap   <= GAP_CYCLES;
                  r_state <= StGap;
               end
            end
            StGap: begin
               if (r_gap <= 8'd1) begin
                  r_gap   <= 8'd0;
                  r_state <= StIdle;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Per-channel pending view (press or release).
   always_comb begin
      oPending = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
`ifdef KEY_EVENT_RELEASE_EN
         oPending[c] = r_pend[2*c] | r_pend[2*c+1];
`else
         oPending[c] = r_pend[c];
`endif
      end
   end

   assign oEvent_valid = r_valid;
   assign oEvent_id    = r_id;
   assign oBusy        = (r_state != StIdle);
`ifdef KEY_EVENT_RELEASE_EN
   assign oEvent_release = r_rel;
`else
   assign oEvent_release = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed self-checking bench for key_event_scheduler (LOCKOUT=20, GAP_CYCLES=4).
// Expected events are queued when a press is driven and popped at each handshake.
module tb_key_event_scheduler;

   localparam int unsigned N_CH = 4;
   localparam int unsigned ID_W = 2;
   localparam logic [15:0] LOCK = 16'd20;
   localparam logic [7:0]  GAP  = 8'd4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N_CH-1:0] trig = 4'hF;
   logic            ready = 1'b0;
   logic            o_valid;
   logic [ID_W-1:0] o_id;
   logic            o_rel;
   logic [N_CH-1:0] o_pend;
   logic            o_busy;
   logic            o_drop;

   int n_chk = 0;
   int n_err = 0;
   int drop_cnt = 0;
   logic [ID_W-1:0] exp_id_q[$];
   logic            exp_rel_q[$];

   key_event_scheduler #(
      .N_CH(N_CH), .ID_W(ID_W), .LOCKOUT(LOCK), .GAP_CYCLES(GAP)
   ) dut (
      .iCLK(clk), .iRST_n(rst_n), .iTrigger_in(trig), .iEvent_ready(ready),
      .oEvent_valid(o_valid), .oEvent_id(o_id), .oEvent_release(o_rel),
      .oPending(o_pend), .oBusy(o_busy), .oDrop_pulse(o_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_drop === 1'b1) drop_cnt <= drop_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [ID_W-1:0] id, input logic rel);
      exp_id_q.push_back(id);
      exp_rel_q.push_back(rel);
   endtask

   // Wait (bounded) for an offer, compare with scoreboard head, then accept it.
   task automatic pop_check(input string tag, input int budget);
      int waited = 0;
      logic [ID_W-1:0] eid;
      logic erel;
      while (o_valid !== 1'b1 && waited < budget) begin
         tick(1);
         waited++;
      end
      chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      if (o_valid !== 1'b1) return;
      chk({tag, "_queued"}, {31'd0, exp_id_q.size() != 0}, 32'd1);
      if (exp_id_q.size() == 0) return;
      eid  = exp_id_q.pop_front();
      erel = exp_rel_q.pop_front();
      chk({tag, "_id"}, 32'(o_id), 32'(eid));
      chk({tag, "_rel"}, {31'd0, o_rel}, {31'd0, erel});
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
   endtask

   task automatic no_event(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         tick(1);
         if (o_valid !== 1'b0) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int d0;
      int waited;

      // Reset state and quiet idle period.
      tick(3);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_pending", 32'(o_pend), 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_drop", {31'd0, o_drop}, 32'd0);
      chk("rst_id", 32'(o_id), 32'd0);
      rst_n = 1'b1;
      no_event("idle_valid", 100);
      chk("idle_drops", 32'(drop_cnt), 32'd0);
      chk("idle_pending", 32'(o_pend), 32'd0);

      // Latency and gap timing on ch2 with ready held high.
      ready = 1'b1;
      trig[2] = 1'b0;
      tick(1);
      chk("lat_k_valid", {31'd0, o_valid}, 32'd0);
      tick(1);
      chk("lat_k1_pend", 32'(o_pend), 32'h4);
      chk("lat_k1_valid", {31'd0, o_valid}, 32'd0);
      tick(1);
      chk("lat_k2_valid", {31'd0, o_valid}, 32'd1);
      chk("lat_k2_id", 32'(o_id), 32'd2);
      chk("lat_k2_busy", {31'd0, o_busy}, 32'd1);
      tick(1);
      chk("hs_valid", {31'd0, o_valid}, 32'd0);
      chk("hs_pend", 32'(o_pend), 32'd0);
      chk("gap_busy0", {31'd0, o_busy}, 32'd1);
      tick(int'(GAP) - 1);
      chk("gap_busy_last", {31'd0, o_busy}, 32'd1);
      tick(1);
      chk("gap_busy_end", {31'd0, o_busy}, 32'd0);
      ready = 1'b0;
      trig[2] = 1'b1;
      tick(5);

      // Bounce on ch1 inside lockout: one event, one drop; then a clean press.
      d0 = drop_cnt;
      trig[1] = 1'b0;
      push(2'd1, 1'b0);
      tick(3);
      trig[1] = 1'b1;
      tick(3);
      trig[1] = 1'b0;
      tick(3);
      chk("bounce_drops", 32'(drop_cnt - d0), 32'd1);
      chk("bounce_pend", 32'(o_pend), 32'h2);
      pop_check("bounce_ev", 10);
      tick(25);
      trig[1] = 1'b1;
      tick(2);
      trig[1] = 1'b0;
      push(2'd1, 1'b0);
      pop_check("clean_ev", 10);
      chk("clean_drops", 32'(drop_cnt - d0), 32'd1);
      trig[1] = 1'b1;
      tick(30);

      // Simultaneous presses after a reset (pointer back at 0).
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      trig = 4'b0100;
      push(2'd0, 1'b0);
      push(2'd1, 1'b0);
      push(2'd3, 1'b0);
      tick(2);
      chk("simul_pend", 32'(o_pend), 32'hB);
      pop_check("simul_a", 20);
      pop_check("simul_b", 20);
      pop_check("simul_c", 20);
      trig = 4'hF;
      tick(30);
      trig = 4'b0110;
      push(2'd0, 1'b0);
      push(2'd3, 1'b0);
      pop_check("wrap_a", 20);
      pop_check("wrap_b", 20);
      chk("wrap_qempty", 32'(exp_id_q.size()), 32'd0);
      trig = 4'hF;
      tick(30);

      // Stall with ready low, then asynchronous reset mid-offer.
      trig[2] = 1'b0;
      waited = 0;
      while (o_valid !== 1'b1 && waited < 10) begin
         tick(1);
         waited++;
      end
      chk("stall_offer", {31'd0, o_valid}, 32'd1);
      repeat (50) begin
         tick(1);
         chk("stall_valid", {31'd0, o_valid}, 32'd1);
         chk("stall_id", 32'(o_id), 32'd2);
      end
      chk("stall_pend", 32'(o_pend), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_pend", 32'(o_pend), 32'd0);
      chk("arst_busy", {31'd0, o_busy}, 32'd0);
      trig[2] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      no_event("arst_quiet", 30);

      // Press then release on ch0, 100 cycles apart.
      trig[0] = 1'b0;
      push(2'd0, 1'b0);
      pop_check("press_ev", 10);
      tick(100);
      trig[0] = 1'b1;
`ifdef KEY_EVENT_RELEASE_EN
      push(2'd0, 1'b1);
      pop_check("release_ev", 10);
`else
      no_event("release_ignored", 60);
`endif
      chk("final_qempty", 32'(exp_id_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Multi-channel key controller: detects the press edge on each of N_CH raw key lines, applies a per-channel lockout (debounce) window, queues at most one pending press per channel, and hands events one at a time to a single consumer.
- Handoff uses a valid/ready handshake with round-robin fairness.
- Sits between board key inputs and the UI/command logic; it replaces ad-hoc per-key debounce pulses with one arbitrated event stream.

Parameters:
- N_CH, 4, number of key channels.
- ID_W, 2, width of the channel id; must satisfy 2**ID_W >= N_CH.
- LOCKOUT, 16'd50000, per-channel debounce window in iCLK cycles; legal range 1..65535; counters are 16 bits.
- GAP_CYCLES, 4, idle cycles forced between consecutive accepted events; legal range 1..255; counter is 8 bits.

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iTrigger_in  in  N_CH  raw key lines; idle high, press = falling edge.
- iEvent_ready  in  1  consumer ready.
- oEvent_valid  out  1  event offered.
- oEvent_id  out  ID_W  channel of the offered event.
- oEvent_release  out  1  offered event is a release (see Optional Feature).
- oPending  out  N_CH  per-channel pending flags.
- oBusy  out  1  high when the FSM is not in IDLE.
- oDrop_pulse  out  1  one-cycle pulse when any edge is discarded.

Behaviour:
- Reset, asynchronous: per-channel 2-stage delay registers = 2'b11, so no spurious edge after reset.
- Reset, asynchronous: lockout counters = 0, pending = 0, RR pointer = 0, FSM = IDLE, gap counter = 0.
- Reset, asynchronous: all outputs 0. Asserting reset mid-handshake drops the in-flight event with no further effect.
- Edge detect, per channel: delay register {older, newer} shifts iTrigger_in in each cycle. Falling flag = (older==1 && newer==0), combinational.
- Latency: input first sampled low at edge k → flag high during cycle k+1 → pending set at edge k+1 → oEvent_valid high after edge k+2 when the FSM is idle.
- Lockout: a falling flag on a channel whose lockout counter is 0 sets pending and loads the counter with LOCKOUT.
- Lockout countdown: the counter decrements by 1 per cycle while nonzero.
- Lockout drop: a falling flag while the counter is nonzero is discarded and pulses oDrop_pulse.
- Pending already set: a falling flag with counter 0 but pending still set is also discarded with oDrop_pulse. Pending is a single bit per channel, never a count.
- oDrop_pulse is the OR of all channel drops in that cycle.
- Set/clear collision: when a pending bit is cleared by a handshake in the same cycle that channel's falling flag is accepted, set wins and the bit stays 1.
- FSM state IDLE: if any pending bit is set, select the first set channel scanning upward from the RR pointer with wrap-around; latch its id; go to OFFER.
- FSM state OFFER: oEvent_valid=1 and oEvent_id held stable until iEvent_ready=1. On the handshake cycle: clear that pending bit, set RR pointer = id+1 mod N_CH, load gap counter with GAP_CYCLES, go to GAP.
- OFFER with ready low: valid never drops.
- FSM state GAP: decrement the gap counter; at 1 → IDLE. New edges continue to set pending during GAP.
- Simultaneous edges on several channels all set pending in the same cycle; they are served in RR order.
- oBusy = (state != IDLE). oPending mirrors the pending register.

Optional Feature:
- Macro: KEY_EVENT_RELEASE_EN.
- Defined: each channel also detects the rising flag (older==0 && newer==1) into a second pending bit, with its own lockout counter and identical drop rules.
- Defined, arbitration: the arbiter treats 2*N_CH request slots; slot order within a channel is press before release.
- Defined, outputs: oEvent_release=1 when a release is offered; oPending shows press|release per channel.
- Undefined: rising edges are ignored and oEvent_release is tied 0.

Test Plan:
- Reset release with all keys high; hold 100 cycles → oEvent_valid=0, oDrop_pulse never pulses, oPending=0.
- Ch2 falls at edge k with ready=1 → valid=1, id=2 after edge k+2; handshake same cycle; oBusy low again exactly GAP_CYCLES cycles later.
- LOCKOUT=20: ch1 bounces low/high/low within 10 cycles → one event id=1, one oDrop_pulse; a clean press at cycle 25 → second event.
- Ch0, ch1 and ch3 fall in the same cycle with ready=1 → ids 0,1,3 in order. Next simultaneous ch0+ch3 → ids 0,3, since the pointer is at 0 after id 3 and wraps.
- ready held 0 for 50 cycles with ch2 pending → valid and id=2 stable throughout. Pulse iRST_n low mid-offer → valid=0 immediately, pending=0.
- KEY_EVENT_RELEASE_EN defined: ch0 press then release 100 cycles apart → two events, id=0, oEvent_release 0 then 1. Undefined → only one event.
